// File: rtl/ts_pack_fifo_pkg.sv
// Shared types and constants for the TS symbol-packing FIFO.
// Optional feature macro: TS_PACK_FIFO_FLUSH_EN (see ts_pack_fifo.sv).
package ts_pack_pkg;

  localparam int unsigned TS_SYM_W         = 10;
  localparam int unsigned TS_SYMS_PER_LINE = 3;
  localparam int unsigned TS_DEPTH         = 21;

  // Pointer fields are sized for DEPTH up to 4096 lines and up to 64 slots per line.
  localparam int unsigned PTR_LINE_W = 12;
  localparam int unsigned PTR_SLOT_W = 6;

  typedef logic [PTR_LINE_W-1:0] ts_line_t;
  typedef logic [PTR_SLOT_W-1:0] ts_slot_t;

  typedef struct packed {
    ts_line_t line;
    ts_slot_t slot;
  } ts_ptr_t;

  // Accept combination for one cycle, encoded as {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } ts_op_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ts_pack_fifo_if.sv
// Handshake, data and status bundle of the TS symbol-packing FIFO.
interface ts_pack_fifo_if import ts_pack_pkg::*; #(
  parameter int unsigned SYM_W = TS_SYM_W,
  parameter int unsigned LVL_W = clog2(TS_DEPTH * TS_SYMS_PER_LINE + 1)
);

  logic             WR_VALID;
  logic             WR_READY;
  logic [SYM_W-1:0] WR_DATA;
  logic             RD_VALID;
  logic             RD_READY;
  logic [SYM_W-1:0] RD_DATA;
  logic             FULL;
  logic             EMPTY;
  logic [LVL_W-1:0] LEVEL;

  // FIFO side
  modport slave (
    input  WR_VALID, WR_DATA, RD_READY,
    output WR_READY, RD_VALID, RD_DATA, FULL, EMPTY, LEVEL
  );

  // Producer/consumer side
  modport master (
    output WR_VALID, WR_DATA, RD_READY,
    input  WR_READY, RD_VALID, RD_DATA, FULL, EMPTY, LEVEL
  );

endinterface

// File: rtl/ts_pack_fifo_ptr.sv
// Line/slot pointer: slot counts up to SYMS_PER_LINE-1, then carries into
// the line index, which wraps after DEPTH-1. Synchronous clear has priority.
module ts_pack_ptr import ts_pack_pkg::*; #(
  parameter int unsigned SYMS_PER_LINE = TS_SYMS_PER_LINE,
  parameter int unsigned DEPTH         = TS_DEPTH
) (
  input  logic    clk_i,
  input  logic    clr_i,
  input  logic    adv_i,
  output ts_ptr_t ptr_o
);

  localparam ts_slot_t SLOT_LAST = ts_slot_t'(SYMS_PER_LINE - 1);
  localparam ts_line_t LINE_LAST = ts_line_t'(DEPTH - 1);

  ts_ptr_t ptr_q;
  ts_ptr_t ptr_d;

  // Next pointer: advance with slot-to-line carry and line wrap
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      if (ptr_q.slot == SLOT_LAST) begin
        ptr_d.slot = '0;
        ptr_d.line = (ptr_q.line == LINE_LAST) ? '0 : ptr_q.line + ts_line_t'(1);
      end else begin
        ptr_d.slot = ptr_q.slot + ts_slot_t'(1);
      end
    end
  end

  // Pointer register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ts_pack_fifo.sv
// TS symbol-packing FIFO: SYM_W-bit symbols packed SYMS_PER_LINE per line
// into a DEPTH-line array, read back in order with show-ahead data.
// Optional macro TS_PACK_FIFO_FLUSH_EN adds a FLUSH input that clears
// pointers, LEVEL and flags like RESET (RESET still has priority).
module ts_pack_fifo import ts_pack_pkg::*; #(
  parameter int unsigned SYM_W         = TS_SYM_W,
  parameter int unsigned SYMS_PER_LINE = TS_SYMS_PER_LINE,
  parameter int unsigned DEPTH         = TS_DEPTH
) (
  input  logic CLOCK,
  input  logic RESET,
`ifdef TS_PACK_FIFO_FLUSH_EN
  input  logic FLUSH,
`endif
  ts_pack_fifo_if.slave bus
);

  localparam int unsigned LINE_W = SYM_W * SYMS_PER_LINE;
  localparam int unsigned CAP    = DEPTH * SYMS_PER_LINE;
  localparam int unsigned LVL_W  = clog2(CAP + 1);

  logic [LINE_W-1:0] mem_q [DEPTH];

  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             full_q;
  logic             empty_q;

  logic             clr;
  logic             wr_fire;
  logic             rd_fire;
  ts_op_e           op;
  ts_ptr_t          wr_ptr;
  ts_ptr_t          rd_ptr;
  logic [SYM_W-1:0] rd_sym;

`ifdef TS_PACK_FIFO_FLUSH_EN
  assign clr = RESET | FLUSH;
`else
  assign clr = RESET;
`endif

  assign wr_fire = bus.WR_VALID & ~full_q;
  assign rd_fire = bus.RD_READY & ~empty_q;
  assign op      = ts_op_e'({wr_fire, rd_fire});

  ts_pack_ptr #(
    .SYMS_PER_LINE (SYMS_PER_LINE),
    .DEPTH         (DEPTH)
  ) u_wr_ptr (
    .clk_i (CLOCK),
    .clr_i (clr),
    .adv_i (wr_fire),
    .ptr_o (wr_ptr)
  );

  ts_pack_ptr #(
    .SYMS_PER_LINE (SYMS_PER_LINE),
    .DEPTH         (DEPTH)
  ) u_rd_ptr (
    .clk_i (CLOCK),
    .clr_i (clr),
    .adv_i (rd_fire),
    .ptr_o (rd_ptr)
  );

  // Storage write: only the addressed slot of the addressed line changes.
  // Line/slot decode is an explicit compare so the full pointer fields
  // drive the address, independent of how wide the package fields are.
  always_ff @(posedge CLOCK) begin
    if (wr_fire && !clr) begin
      for (int unsigned l = 0; l < DEPTH; l++) begin
        for (int unsigned s = 0; s < SYMS_PER_LINE; s++) begin
          if (wr_ptr.line == ts_line_t'(l) && wr_ptr.slot == ts_slot_t'(s)) begin
            mem_q[l][s*SYM_W +: SYM_W] <= bus.WR_DATA;
          end
        end
      end
    end
  end

  // Show-ahead read mux of the oldest symbol
  always_comb begin
    rd_sym = '0;
    for (int unsigned l = 0; l < DEPTH; l++) begin
      for (int unsigned s = 0; s < SYMS_PER_LINE; s++) begin
        if (rd_ptr.line == ts_line_t'(l) && rd_ptr.slot == ts_slot_t'(s)) begin
          rd_sym = mem_q[l][s*SYM_W +: SYM_W];
        end
      end
    end
  end

  // Next fill level from the accept combination
  always_comb begin
    level_d = level_q;
    unique case (op)
      OP_WR:   level_d = level_q + LVL_W'(1);
      OP_RD:   level_d = level_q - LVL_W'(1);
      OP_BOTH: level_d = level_q;
      OP_IDLE: level_d = level_q;
      default: level_d = level_q;
    endcase
  end

  // Level and flags; flags derive from the next level so they track LEVEL
  always_ff @(posedge CLOCK) begin
    if (clr) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(CAP));
      empty_q <= (level_d == '0);
    end
  end

  assign bus.WR_READY = ~full_q;
  assign bus.RD_VALID = ~empty_q;
  assign bus.RD_DATA  = empty_q ? '0 : rd_sym;
  assign bus.FULL     = full_q;
  assign bus.EMPTY    = empty_q;
  assign bus.LEVEL    = level_q;

endmodule
